// File: rtl/bootram_ctrl_if.sv
// CPU-side request/response bundle for the boot RAM controller.
// The master drives the request; the slave answers with a one-cycle ready pulse and registered rdata.
interface bootram_ctrl_if;
  logic        mem_s_valid;
  logic        mem_s_ready;
  logic [31:0] mem_s_addr;
  logic [31:0] mem_s_wdata;
  logic [3:0]  mem_s_wstrb;
  logic [31:0] mem_s_rdata;

  modport master (
    output mem_s_valid,
    output mem_s_addr,
    output mem_s_wdata,
    output mem_s_wstrb,
    input  mem_s_ready,
    input  mem_s_rdata
  );

  modport slave (
    input  mem_s_valid,
    input  mem_s_addr,
    input  mem_s_wdata,
    input  mem_s_wstrb,
    output mem_s_ready,
    output mem_s_rdata
  );
endinterface

// File: rtl/bootram_ctrl.sv
// Boot RAM controller: four byte-lane sync RAMs behind a valid/ready CPU port.
// Reads complete two cycles after valid, writes one; no request is taken outside IDLE.
module bootram_ctrl #(
  parameter int ADDR_WIDTH = 11,
  parameter int WRITABLE   = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  bootram_ctrl_if.slave         mem_s,
  output logic [ADDR_WIDTH-1:0] ram_ad,
  output logic                  ram_ce,
  output logic                  ram_oce,
  output logic [3:0]            ram_wre,
  output logic [31:0]           ram_din,
  input  logic [31:0]           ram_dout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_rdata;
  logic        w_capture;
  logic        w_unused_addr;

  // Only the word index is decoded; upper bits alias and byte offset is dropped.
  assign w_unused_addr = ^{mem_s.mem_s_addr[31:ADDR_WIDTH+2], mem_s.mem_s_addr[1:0]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    ram_ce    = 1'b0;
    ram_wre   = 4'b0000;
    ram_ad    = mem_s.mem_s_addr[ADDR_WIDTH+1:2];
    ram_din   = mem_s.mem_s_wdata;
    w_capture = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mem_s.mem_s_valid) begin
          ram_ce = 1'b1;
          if (mem_s.mem_s_wstrb == 4'b0000) begin
            w_next = S_READ;
          end else begin
            ram_wre = (WRITABLE != 0) ? mem_s.mem_s_wstrb : 4'b0000;
            w_next  = S_RESP;
          end
        end
      end
      S_READ: begin
        w_capture = 1'b1;
        w_next    = S_RESP;
      end
      S_RESP: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rdata <= 32'h0000_0000;
    end else if (w_capture) begin
      r_rdata <= ram_dout;
    end
  end

  assign mem_s.mem_s_ready = (r_state == S_RESP);
  assign mem_s.mem_s_rdata = r_rdata;
  assign ram_oce           = 1'b1;

endmodule

// File: doc/bootram_ctrl.md
BOOTRAM_CTRL -- requirements
Module: bootram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 11, meaning word-address width (2^11 words x 32 bit = 8 KB).
REQ-002 SHALL have parameter WRITABLE, default 1, meaning 1 = writes reach RAM, 0 = writes acknowledged but discarded.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-006 SHALL have port mem_s_valid  input  1  CPU request valid.
REQ-007 SHALL have port mem_s_ready  output  1  one-cycle completion pulse.
REQ-008 SHALL have port mem_s_addr  input  32  byte address; only bits [ADDR_WIDTH+1:2] used.
REQ-009 SHALL have port mem_s_wdata  input  32  write data.
REQ-010 SHALL have port mem_s_wstrb  input  4  byte write strobes; 0 = read.
REQ-011 SHALL have port mem_s_rdata  output  32  registered read data.
REQ-012 SHALL have port ram_ad  output  ADDR_WIDTH  word address to all four byte-lane RAMs.
REQ-013 SHALL have port ram_ce  output  1  clock enable to all lanes.
REQ-014 SHALL have port ram_oce  output  1  output clock enable, tied 1.
REQ-015 SHALL have port ram_wre  output  4  per-lane write enable; bit k drives lane k (bits 8k+7:8k).
REQ-016 SHALL have port ram_din  output  32  write data to lanes, lane k = bits 8k+7:8k.
REQ-017 SHALL have port ram_dout  input  32  concatenated lane outputs, valid one clock after a read ce edge (bypass read mode).

Function
REQ-018 SHALL implement states IDLE, READ, RESP.
REQ-019 IDLE: when mem_s_valid=1, ram_ce=1 and ram_ad=mem_s_addr[ADDR_WIDTH+1:2] combinationally in that cycle; otherwise ram_ce=0, ram_wre=0.
REQ-020 IDLE with valid and wstrb=0: next state READ; ram_wre=0.
REQ-021 IDLE with valid and wstrb!=0: ram_wre=wstrb when WRITABLE=1, else 0000; ram_din=mem_s_wdata; next state RESP.
REQ-022 READ: ram_ce=0; on the exiting edge mem_s_rdata <= ram_dout; next state RESP.
REQ-023 RESP: mem_s_ready=1 for exactly this cycle; ram_ce=0; next state IDLE unconditionally.
REQ-024 mem_s_ready SHALL be 0 in IDLE and READ; read latency = valid cycle T -> ready in cycle T+2; write latency = ready in cycle T+1.
REQ-025 A request SHALL NOT be accepted in READ or RESP; a valid still high in the IDLE cycle after RESP is treated as a new request (protocol requires CPU to drop valid after ready).
REQ-026 mem_s_rdata SHALL hold its value until the next read capture; writes never change it.
REQ-027 Partial strobes (e.g. 0110) SHALL write only the enabled lanes; other lanes untouched.
REQ-028 Address bits above ADDR_WIDTH+1 and bits [1:0] SHALL be ignored (wrap-around: 0x2000 aliases 0x0000).
REQ-029 If valid deasserts while in READ (protocol violation), the transaction SHALL still complete with one ready pulse.
REQ-030 ram_oce SHALL be constant 1.

Reset
REQ-031 resetn=0 SHALL asynchronously force state IDLE, mem_s_ready=0, mem_s_rdata=0.
REQ-032 Reset asserted in READ or RESP SHALL abort the transaction with no ready pulse; RAM contents unaffected except a write already clocked.
REQ-033 After resetn rises, the first valid SHALL be accepted in the first clock cycle.

Verification
REQ-034 Read after init: RAM word 0 preloaded 0x00F00520, valid addr 0x0, wstrb 0 at cycle T -> ready=1 only in T+2, rdata=0x00F00520.
REQ-035 Full write then read: write 0xDEADBEEF, wstrb 1111, addr 0x10 -> ready at T+1, ram_wre=1111 and ram_ad=4 in T; read 0x10 -> rdata 0xDEADBEEF.
REQ-036 Byte write: word 0x10=0xDEADBEEF, write 0x00112200 wstrb 0010 -> read returns 0xDEAD22EF.
REQ-037 WRITABLE=0: write 0x12345678 to 0x20 -> ready at T+1, ram_wre=0000, subsequent read returns original content.
REQ-038 Alias: write 0xA5A5A5A5 to 0x2004 -> read of 0x0004 returns 0xA5A5A5A5.
REQ-039 Reset mid-read: resetn=0 in READ -> ready stays 0, rdata=0; next read after release completes with latency 2.
